// File: rtl/bus_bridge_pkg.sv
// Shared constants for bus_bridge: device window base, register offsets and
// the hex-to-seven-segment lookup.
package bus_bridge_pkg;

    localparam logic [19:0] DEV_BASE = 20'hFFFFF;

    localparam logic [11:0] OFF_SEG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;

    localparam int SW_W = 24;

    // Active-high {g,f,e,d,c,b,a} patterns, entry 0 in the low slot.
    localparam logic [15:0][6:0] HEX_SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Active-low segment drive with the decimal point held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return {1'b1, ~HEX_SEG_LUT[nib]};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has differed from it for DEB_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (d_i == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            q_d   = d_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bus_bridge.sv
// CPU data-bus responder: DRAM pass-through plus SEG/TCNT/TDIV/LED/SW registers.
// Define BUS_BRIDGE_DEBOUNCE_EN to insert a debounce filter on each switch.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    output logic [31:0]       rdata,
    output logic [31:0]       dram_addr,
    output logic [31:0]       dram_wdata,
    output logic              dram_we,
    input  logic [31:0]       dram_rdata,
    input  logic [SW_W-1:0]   device_sw,
    output logic [SW_W-1:0]   device_led,
    output logic [7:0]        dig_en,
    output logic [7:0]        seg
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must be at least 1");
    end

    logic        in_dev;
    logic [11:0] off;
    logic        dev_we;

    logic [31:0]       seg_val_q, seg_val_d;
    logic [31:0]       tcnt_q, tcnt_d;
    logic [31:0]       tdiv_q, tdiv_d;
    logic [31:0]       presc_q, presc_d;
    logic [SW_W-1:0]   led_q, led_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [SW_W-1:0]   sync1_q, sync2_q;
    logic [SW_W-1:0]   sw_filt;

    assign in_dev = (addr[31:12] == DEV_BASE);
    assign off    = addr[11:0];
    assign dev_we = we & in_dev;

    assign dram_addr  = addr;
    assign dram_wdata = wdata;
    assign dram_we    = we & ~in_dev;

    always_comb begin
        seg_val_d = seg_val_q;
        tdiv_d    = tdiv_q;
        led_d     = led_q;
        if (presc_q == tdiv_q) begin
            presc_d = '0;
            tcnt_d  = tcnt_q + 32'd1;
        end else begin
            presc_d = presc_q + 32'd1;
            tcnt_d  = tcnt_q;
        end
        // A store to TCNT overrides any increment scheduled for this edge.
        if (dev_we) begin
            case (off)
                OFF_SEG:  seg_val_d = wdata;
                OFF_TCNT: begin
                    tcnt_d  = wdata;
                    presc_d = '0;
                end
                OFF_TDIV: tdiv_d = wdata;
                OFF_LED:  led_d  = wdata[SW_W-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_val_q  <= '0;
            tcnt_q     <= '0;
            tdiv_q     <= '0;
            presc_q    <= '0;
            led_q      <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            seg_val_q  <= seg_val_d;
            tcnt_q     <= tcnt_d;
            tdiv_q     <= tdiv_d;
            presc_q    <= presc_d;
            led_q      <= led_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sync1_q    <= device_sw;
            sync2_q    <= sync1_q;
        end
    end

`ifdef BUS_BRIDGE_DEBOUNCE_EN
    for (genvar i = 0; i < SW_W; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .d_i (sync2_q[i]),
            .q_o (sw_filt[i])
        );
    end
`else
    assign sw_filt = sync2_q;
`endif

    // Zero-latency load path for the single-cycle datapath.
    always_comb begin
        rdata = '0;
        if (!in_dev) begin
            rdata = dram_rdata;
        end else begin
            case (off)
                OFF_SEG:  rdata = seg_val_q;
                OFF_TCNT: rdata = tcnt_q;
                OFF_TDIV: rdata = tdiv_q;
                OFF_LED:  rdata = {{(32-SW_W){1'b0}}, led_q};
                OFF_SW:   rdata = {{(32-SW_W){1'b0}}, sw_filt};
                default:  rdata = '0;
            endcase
        end
    end

    assign device_led = led_q;
    assign dig_en     = ~(8'b1 << idx_q);
    assign seg        = hex_to_seg(seg_val_q[{idx_q, 2'b00} +: 4]);

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed scenarios plus randomized
// register traffic against a behavioural model of the register map.
module tb_bus_bridge;

    localparam int SCAN_DIV   = 2;
    localparam int DEB_CYCLES = 4;
`ifdef BUS_BRIDGE_DEBOUNCE_EN
    localparam int SW_LAT = 2 + DEB_CYCLES;
`else
    localparam int SW_LAT = 2;
`endif

    localparam logic [31:0] A_SEG  = 32'hFFFFF000;
    localparam logic [31:0] A_TCNT = 32'hFFFFF020;
    localparam logic [31:0] A_TDIV = 32'hFFFFF024;
    localparam logic [31:0] A_LED  = 32'hFFFFF060;
    localparam logic [31:0] A_SW   = 32'hFFFFF070;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_we;
    logic [31:0] dram_rdata;
    logic [23:0] device_sw;
    logic [23:0] device_led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fails  = 0;
    int n_edge;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Register-map model for the randomized traffic.
    logic [31:0] m_seg;
    logic [31:0] m_tdiv;
    logic [23:0] m_led;

    bus_bridge #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .rdata      (rdata),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_we    (dram_we),
        .dram_rdata (dram_rdata),
        .device_sw  (device_sw),
        .device_led (device_led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; the scan position is a function of it.
    always @(posedge clk or posedge rst) begin
        if (rst) n_edge <= 0;
        else     n_edge <= n_edge + 1;
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dig_en !== 8'hFE) begin n_fails++; $display("FAIL reset_dig_en got=%h exp=fe", dig_en); end
        n_checks++;
        if (seg !== 8'hC0) begin n_fails++; $display("FAIL reset_seg got=%h exp=c0", seg); end
        n_checks++;
        if (device_led !== 24'h0) begin n_fails++; $display("FAIL reset_led got=%h exp=0", device_led); end
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h0) begin n_fails++; $display("FAIL reset_tcnt got=%h exp=0", r); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dram();
        logic [31:0] a, d, r;
        @(negedge clk);
        addr = 32'h00000010; wdata = 32'hDEADBEEF; we = 1'b1;
        #1;
        n_checks++;
        if (dram_we !== 1'b1) begin n_fails++; $display("FAIL dram_we got=%b exp=1", dram_we); end
        n_checks++;
        if (dram_wdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL dram_wdata got=%h exp=deadbeef", dram_wdata); end
        n_checks++;
        if (dram_addr !== 32'h00000010) begin n_fails++; $display("FAIL dram_addr got=%h exp=00000010", dram_addr); end
        we = 1'b0; dram_rdata = 32'h12345678;
        #1;
        n_checks++;
        if (rdata !== 32'h12345678) begin n_fails++; $display("FAIL dram_rdata got=%h exp=12345678", rdata); end
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
            d = $urandom;
            dram_rdata = $urandom;
            addr = a; wdata = d; we = 1'b1;
            #1;
            n_checks++;
            if (dram_we !== 1'b1 || dram_wdata !== d || dram_addr !== a) begin
                n_fails++;
                $display("FAIL dram_rand_wr got we=%b a=%h d=%h exp we=1 a=%h d=%h", dram_we, dram_addr, dram_wdata, a, d);
            end
            we = 1'b0;
            do_read(a, r);
            n_checks++;
            if (r !== dram_rdata) begin n_fails++; $display("FAIL dram_rand_rd got=%h exp=%h", r, dram_rdata); end
        end
        we = 1'b0;
    endtask

    task automatic test_led();
        logic [31:0] r;
        @(negedge clk);
        addr = A_LED; wdata = 32'hFFA5A5A5; we = 1'b1;
        #1;
        n_checks++;
        if (dram_we !== 1'b0) begin n_fails++; $display("FAIL led_dram_we got=%b exp=0", dram_we); end
        @(posedge clk);
        #1;
        we = 1'b0;
        n_checks++;
        if (device_led !== 24'hA5A5A5) begin n_fails++; $display("FAIL led_out got=%h exp=a5a5a5", device_led); end
        do_read(A_LED, r);
        n_checks++;
        if (r !== 32'h00A5A5A5) begin n_fails++; $display("FAIL led_read got=%h exp=00a5a5a5", r); end
        m_led = 24'hA5A5A5;
    endtask

    task automatic test_switch();
        logic [31:0] r;
        logic [23:0] v, old;
        @(negedge clk);
        device_sw = 24'h00F00F;
        for (int k = 1; k <= SW_LAT + 1; k++) begin
            @(posedge clk);
            do_read(A_SW, r);
            n_checks++;
            if (r !== ((k >= SW_LAT) ? 32'h0000F00F : 32'h0)) begin
                n_fails++;
                $display("FAIL sw_latency k=%0d got=%h exp=%h", k, r, (k >= SW_LAT) ? 32'h0000F00F : 32'h0);
            end
        end
`ifdef BUS_BRIDGE_DEBOUNCE_EN
        @(negedge clk);
        device_sw = 24'h0FF0F0;
        repeat (2) @(negedge clk);
        device_sw = 24'h00F00F;
        repeat (SW_LAT + 4) @(posedge clk);
        do_read(A_SW, r);
        n_checks++;
        if (r !== 32'h0000F00F) begin n_fails++; $display("FAIL sw_glitch got=%h exp=0000f00f", r); end
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            old = device_sw;
            v = 24'($urandom);
            device_sw = v;
            repeat (SW_LAT - 1) @(posedge clk);
            do_read(A_SW, r);
            n_checks++;
            if (r !== {8'h0, old}) begin n_fails++; $display("FAIL sw_rand_early got=%h exp=%h", r, {8'h0, old}); end
            @(posedge clk);
            do_read(A_SW, r);
            n_checks++;
            if (r !== {8'h0, v}) begin n_fails++; $display("FAIL sw_rand got=%h exp=%h", r, {8'h0, v}); end
        end
    endtask

    task automatic test_timer();
        logic [31:0] r, v, exp_v;
        int d, k;
        do_write(A_TDIV, 32'd3);
        do_write(A_TCNT, 32'd0);
        repeat (4) @(posedge clk);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'd1) begin n_fails++; $display("FAIL timer_div3_4 got=%h exp=1", r); end
        repeat (4) @(posedge clk);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'd2) begin n_fails++; $display("FAIL timer_div3_8 got=%h exp=2", r); end

        do_write(A_TDIV, 32'd0);
        do_write(A_TCNT, 32'hFFFFFFFF);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'hFFFFFFFF) begin n_fails++; $display("FAIL timer_load got=%h exp=ffffffff", r); end
        @(posedge clk);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h0) begin n_fails++; $display("FAIL timer_wrap got=%h exp=0", r); end

        do_write(A_TCNT, 32'h100);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h100) begin n_fails++; $display("FAIL timer_write_tick got=%h exp=100", r); end

        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(0, 5);
            v = $urandom;
            k = $urandom_range(0, 20);
            do_write(A_TDIV, 32'(d));
            do_write(A_TCNT, v);
            repeat (k) @(posedge clk);
            do_read(A_TCNT, r);
            exp_v = v + 32'(k / (d + 1));
            n_checks++;
            if (r !== exp_v) begin n_fails++; $display("FAIL timer_rand div=%0d k=%0d got=%h exp=%h", d, k, r, exp_v); end
        end
        m_tdiv = 32'(d);
    endtask

    task automatic test_seg();
        logic [31:0] val;
        logic [7:0]  exp_dig, exp_seg;
        int idx;
        for (int pass = 0; pass < 2; pass++) begin
            val = (pass == 0) ? 32'h76543210 : $urandom;
            do_write(A_SEG, val);
            m_seg = val;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                idx = (n_edge / SCAN_DIV) % 8;
                exp_dig = ~(8'b1 << idx);
                exp_seg = seg_tab[(val >> (4 * idx)) & 32'hF];
                n_checks++;
                if (dig_en !== exp_dig || seg !== exp_seg) begin
                    n_fails++;
                    $display("FAIL seg_scan val=%h got dig=%h seg=%h exp dig=%h seg=%h", val, dig_en, seg, exp_dig, exp_seg);
                end
            end
        end
    endtask

    task automatic test_random_regs();
        logic [31:0] offs [7] = '{32'h000, 32'h024, 32'h060, 32'h070, 32'h004, 32'h064, 32'hFFC};
        logic [31:0] a, d, r, exp_r;
        for (int i = 0; i < 40; i++) begin
            a = 32'hFFFFF000 | offs[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d);
                case (a[11:0])
                    12'h000: m_seg  = d;
                    12'h024: m_tdiv = d;
                    12'h060: m_led  = d[23:0];
                    default: ;
                endcase
                n_checks++;
                if (device_led !== m_led) begin n_fails++; $display("FAIL rand_led_out got=%h exp=%h", device_led, m_led); end
            end else begin
                dram_rdata = $urandom;
                do_read(a, r);
                case (a[11:0])
                    12'h000: exp_r = m_seg;
                    12'h024: exp_r = m_tdiv;
                    12'h060: exp_r = {8'h0, m_led};
                    12'h070: exp_r = {8'h0, device_sw};
                    default: exp_r = 32'h0;
                endcase
                n_checks++;
                if (r !== exp_r) begin n_fails++; $display("FAIL rand_read a=%h got=%h exp=%h", a, r, exp_r); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        do_write(A_TDIV, 32'd0);
        do_write(A_TCNT, 32'd5);
        do_write(A_LED, 32'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (device_led !== 24'h0) begin n_fails++; $display("FAIL rstmid_led got=%h exp=0", device_led); end
        n_checks++;
        if (dig_en !== 8'hFE || seg !== 8'hC0) begin
            n_fails++; $display("FAIL rstmid_disp got dig=%h seg=%h exp dig=fe seg=c0", dig_en, seg);
        end
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h0) begin n_fails++; $display("FAIL rstmid_tcnt got=%h exp=0", r); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h0) begin n_fails++; $display("FAIL rstmid_tcnt_release got=%h exp=0", r); end
        @(posedge clk);
        do_read(A_TCNT, r);
        n_checks++;
        if (r !== 32'h1) begin n_fails++; $display("FAIL rstmid_resume got=%h exp=1", r); end
    endtask

    initial begin
        rst = 1'b1;
        addr = '0; wdata = '0; we = 1'b0;
        dram_rdata = '0; device_sw = '0;
        m_seg = '0; m_tdiv = '0; m_led = '0;
        test_reset();
        test_dram();
        test_led();
        test_switch();
        test_timer();
        test_seg();
        test_random_regs();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
